// File: rtl/alu_operand_stage_if.sv
// ID/EX operand-stage bus: decoded ID bundle, forwarding sources and the ALU-facing EX outputs.
// The master drives the ID and forwarding side; the slave (the stage itself) drives the EX side.
interface alu_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [3:0]        id_alu_op;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic [4:0]        id_shamt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              exm_reg_write;
  logic [REG_AW-1:0] exm_rd;
  logic [DATA_W-1:0] exm_result;
  logic              mw_reg_write;
  logic [REG_AW-1:0] mw_rd;
  logic [DATA_W-1:0] mw_result;
  logic              stall_id;
  logic              ex_valid;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_illegal_op;

  modport master (
    output id_valid, id_alu_op, id_rs, id_rt, id_rs_data, id_rt_data, id_imm,
           id_use_imm, id_shamt, id_rd, id_reg_write, id_mem_read, flush,
           exm_reg_write, exm_rd, exm_result, mw_reg_write, mw_rd, mw_result,
    input  stall_id, ex_valid, alu_op, alu_in1, alu_in2, ex_rd, ex_reg_write,
           ex_mem_read, ex_illegal_op
  );

  modport slave (
    input  id_valid, id_alu_op, id_rs, id_rt, id_rs_data, id_rt_data, id_imm,
           id_use_imm, id_shamt, id_rd, id_reg_write, id_mem_read, flush,
           exm_reg_write, exm_rd, exm_result, mw_reg_write, mw_rd, mw_result,
    output stall_id, ex_valid, alu_op, alu_in1, alu_in2, ex_rd, ex_reg_write,
           ex_mem_read, ex_illegal_op
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register for the MIPS ALU: latches the decoded bundle, resolves forwarded operands,
// detects load-use hazards (stall + bubble), honours flush and flags illegal opcodes.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  alu_operand_stage_if.slave bus
);

  logic              ex_valid_q, ex_valid_d;
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              use_imm_q, use_imm_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;

  logic              stall;
  logic              illegal;
  logic              is_shift;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] rf_data,
    input logic              exm_we,
    input logic [REG_AW-1:0] exm_rd,
    input logic [DATA_W-1:0] exm_res,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] r;
    if (src == '0)                        r = '0;
    else if (exm_we && (exm_rd == src))   r = exm_res;
    else if (mw_we && (mw_rd == src))     r = mw_res;
    else                                  r = rf_data;
    return r;
  endfunction

  // Load-use hazard: a load in EX whose destination feeds the instruction waiting in ID
  assign stall = bus.id_valid & ex_valid_q & mem_read_q & (rd_q != '0) &
                 ((rd_q == bus.id_rs) | ((rd_q == bus.id_rt) & ~bus.id_use_imm));

  always_comb begin
    ex_valid_d  = ex_valid_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    shamt_d     = shamt_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (bus.flush || stall) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d  = bus.id_valid;
      op_d        = bus.id_alu_op;
      rs_d        = bus.id_rs;
      rt_d        = bus.id_rt;
      rs_data_d   = bus.id_rs_data;
      rt_data_d   = bus.id_rt_data;
      imm_d       = bus.id_imm;
      use_imm_d   = bus.id_use_imm;
      shamt_d     = bus.id_shamt;
      rd_d        = bus.id_rd;
      reg_write_d = bus.id_reg_write;
      mem_read_d  = bus.id_mem_read;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      shamt_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      shamt_q     <= shamt_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  // EX stage: forwarding uses the EX-resident source numbers against the live downstream stages
  assign fwd_rs = fwd_sel(rs_q, rs_data_q, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                          bus.mw_reg_write, bus.mw_rd, bus.mw_result);
  assign fwd_rt = fwd_sel(rt_q, rt_data_q, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                          bus.mw_reg_write, bus.mw_rd, bus.mw_result);

  assign is_shift = (op_q == 4'd6) || (op_q == 4'd7);
  assign illegal  = ex_valid_q & (op_q > 4'd9);

  assign bus.stall_id      = stall;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_op        = op_q;
  assign bus.alu_in1       = is_shift ? fwd_rt : fwd_rs;
  assign bus.alu_in2       = is_shift ? {{(DATA_W-5){1'b0}}, shamt_q}
                                      : (use_imm_q ? imm_q : fwd_rt);
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q & ex_valid_q & ~illegal;
  assign bus.ex_mem_read   = mem_read_q & ex_valid_q;
  assign bus.ex_illegal_op = illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: the driver pushes the expected EX view for each cycle,
// a negedge monitor pops and compares it against the DUT.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  alu_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    bit          stall;
    bit          v;
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    bit          rw;
    bit          mr;
    bit          ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".stall_id"},      32'(bus.stall_id),      32'(e.stall));
      chk({e.name, ".ex_valid"},      32'(bus.ex_valid),      32'(e.v));
      chk({e.name, ".ex_reg_write"},  32'(bus.ex_reg_write),  32'(e.rw));
      chk({e.name, ".ex_mem_read"},   32'(bus.ex_mem_read),   32'(e.mr));
      chk({e.name, ".ex_illegal_op"}, 32'(bus.ex_illegal_op), 32'(e.ill));
      if (e.v) begin
        chk({e.name, ".alu_op"},  32'(bus.alu_op), 32'(e.op));
        chk({e.name, ".alu_in1"}, bus.alu_in1,     e.in1);
        chk({e.name, ".alu_in2"}, bus.alu_in2,     e.in2);
        chk({e.name, ".ex_rd"},   32'(bus.ex_rd),  32'(e.rd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idb(input bit v, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                     input bit ui, input logic [4:0] sh, input logic [4:0] rd,
                     input bit rw, input bit mr);
    bus.id_valid     = v;
    bus.id_alu_op    = op;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_use_imm   = ui;
    bus.id_shamt     = sh;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = 1'b0;
  endtask

  task automatic fwd(input bit ew, input logic [4:0] erd, input logic [31:0] eres,
                     input bit mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exm_reg_write = ew;
    bus.exm_rd        = erd;
    bus.exm_result    = eres;
    bus.mw_reg_write  = mw;
    bus.mw_rd         = mrd;
    bus.mw_result     = mres;
  endtask

  task automatic expect_ex(input string name, input bit st, input bit v, input logic [3:0] op,
                           input logic [31:0] in1, input logic [31:0] in2, input logic [4:0] rd,
                           input bit rw, input bit mr, input bit ill);
    exp_t e;
    e.name = name; e.stall = st; e.v = v; e.op = op; e.in1 = in1; e.in2 = in2;
    e.rd = rd; e.rw = rw; e.mr = mr; e.ill = ill;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".ex_valid"},      32'(bus.ex_valid),      32'd0);
    chk({tag, ".ex_reg_write"},  32'(bus.ex_reg_write),  32'd0);
    chk({tag, ".ex_mem_read"},   32'(bus.ex_mem_read),   32'd0);
    chk({tag, ".ex_illegal_op"}, 32'(bus.ex_illegal_op), 32'd0);
    chk({tag, ".alu_op"},        32'(bus.alu_op),        32'd0);
    chk({tag, ".ex_rd"},         32'(bus.ex_rd),         32'd0);
    chk({tag, ".stall_id"},      32'(bus.stall_id),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idb(0, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 5'd0, 0, 0);
    fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_init");
    chk("reset_init.alu_in1", bus.alu_in1, 32'h0);

    // A: add r3,r1,r2 enters ID
    tick(); rst = 1'b0;
    idb(1, 4'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 0, 5'd0, 5'd3, 1, 0);
    expect_ex("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // B: add in EX, no forwarding
    tick();
    fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    idb(1, 4'd0, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 0, 5'd0, 5'd5, 1, 0);
    expect_ex("add_basic", 0, 1, 4'd0, 32'd5, 32'd7, 5'd3, 1, 0, 0);
    // C: EX/MEM beats MEM/WB
    tick();
    fwd(1, 5'd1, 32'hAA, 1, 5'd1, 32'hBB);
    idb(1, 4'd0, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 0, 5'd0, 5'd5, 1, 0);
    expect_ex("fwd_exm_prio", 0, 1, 4'd0, 32'hAA, 32'h22, 5'd5, 1, 0, 0);
    // D: only MEM/WB matches
    tick();
    fwd(0, 5'd1, 32'hAA, 1, 5'd1, 32'hBB);
    idb(1, 4'd0, 5'd0, 5'd2, 32'h33, 32'h22, 32'h0, 0, 5'd0, 5'd5, 1, 0);
    expect_ex("fwd_mw", 0, 1, 4'd0, 32'hBB, 32'h22, 5'd5, 1, 0, 0);
    // E: rs=0 yields zero even when writers target r0
    tick();
    fwd(1, 5'd0, 32'hCC, 1, 5'd0, 32'hDD);
    idb(1, 4'd0, 5'd1, 5'd4, 32'h100, 32'h0, 32'd8, 1, 5'd0, 5'd4, 1, 1);
    expect_ex("fwd_r0", 0, 1, 4'd0, 32'h0, 32'h22, 5'd5, 1, 0, 0);
    // F: lw r4 in EX, dependent sub in ID -> stall
    tick();
    fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    idb(1, 4'd1, 5'd4, 5'd2, 32'h999, 32'h22, 32'h0, 0, 5'd0, 5'd6, 1, 0);
    expect_ex("lw_stall", 1, 1, 4'd0, 32'h100, 32'd8, 5'd4, 1, 1, 0);
    // G: bubble, ID held
    tick();
    expect_ex("bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // H: sub in EX takes the load data from MEM/WB
    tick();
    fwd(0, 5'd0, 32'h0, 1, 5'd4, 32'h1234);
    idb(1, 4'd7, 5'd9, 5'd2, 32'h55, 32'd1, 32'h0, 0, 5'd31, 5'd7, 1, 0);
    expect_ex("sub_after_load", 0, 1, 4'd1, 32'h1234, 32'h22, 5'd6, 1, 0, 0);
    // I: sll in EX; flush the next bundle
    tick();
    fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    idb(1, 4'd0, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 0, 5'd0, 5'd11, 1, 0);
    bus.flush = 1'b1;
    expect_ex("sll_shamt31", 0, 1, 4'd7, 32'd1, 32'd31, 5'd7, 1, 0, 0);
    // J: flushed slot
    tick();
    idb(1, 4'd12, 5'd1, 5'd2, 32'h10, 32'h20, 32'hFFFF_FFF0, 1, 5'd0, 5'd8, 1, 0);
    expect_ex("flushed", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // K: illegal opcode with immediate operand
    tick();
    idb(1, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'd4, 1, 5'd0, 5'd4, 1, 1);
    expect_ex("illegal_imm", 0, 1, 4'd12, 32'h10, 32'hFFFF_FFF0, 5'd8, 0, 0, 1);
    // L: lw r4 in EX; ID uses rt=4 only as imm slot -> no stall
    tick();
    idb(1, 4'd8, 5'd1, 5'd4, 32'h7, 32'h0, 32'd3, 1, 5'd0, 5'd9, 1, 0);
    expect_ex("no_stall_imm", 0, 1, 4'd0, 32'h0, 32'd4, 5'd4, 1, 1, 0);
    // M: addu in EX
    tick();
    idb(1, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 5'd0, 5'd5, 1, 1);
    expect_ex("addu_imm", 0, 1, 4'd8, 32'h7, 32'd3, 5'd9, 1, 0, 0);
    // N: lw r5 in EX, rt hazard together with flush
    tick();
    idb(1, 4'd2, 5'd1, 5'd5, 32'hF0, 32'h0F, 32'h0, 0, 5'd0, 5'd10, 1, 0);
    bus.flush = 1'b1;
    expect_ex("stall_with_flush", 1, 1, 4'd0, 32'h0, 32'h0, 5'd5, 1, 1, 0);
    // O: flush wins, ID held
    tick();
    bus.flush = 1'b0;
    expect_ex("flush_prio", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // P: and loads, rt forwarded from MEM/WB
    tick();
    fwd(0, 5'd0, 32'h0, 1, 5'd5, 32'hFF);
    idb(0, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 5'd0, 0, 0);
    expect_ex("and_fwd_rt", 0, 1, 4'd2, 32'hF0, 32'hFF, 5'd10, 1, 0, 0);
    // Q: invalid ID loaded
    tick();
    fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    idb(1, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 5'd0, 5'd4, 1, 1);
    expect_ex("id_invalid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // R: stall again, then async reset mid-cycle
    tick();
    idb(1, 4'd1, 5'd4, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 5'd6, 1, 0);
    expect_ex("lw_stall2", 1, 1, 4'd0, 32'h0, 32'h0, 5'd4, 1, 1, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("reset_async");
    tick(); rst = 1'b0;
    idb(0, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 5'd0, 0, 0);
    expect_ex("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_ex("post_reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
